// File: rtl/ipsm_pkg.sv
// rtl/ipsm_pkg.sv - shared state type and frame geometry helpers for the frame packer
package ipsm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Pixels per DMEM word
    function automatic int ppw(input int word_w, input int pix_w);
        return word_w / pix_w;
    endfunction

    // Pixels per frame
    function automatic int npix(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

    // DMEM words per frame, last word possibly padded
    function automatic int nwords(input int n_pix, input int pix_per_word);
        return (n_pix + pix_per_word - 1) / pix_per_word;
    endfunction

endpackage

// File: rtl/ipsm_word_packer.sv
// rtl/ipsm_word_packer.sv - packs truncated pixels into wide words; IPSM_INVERT_EN stores inverted pixels
module ipsm_word_packer
    import ipsm_pkg::*;
#(
    parameter int PIX_IN_W = 12,
    parameter int PIX_W    = 8,
    parameter int WORD_W   = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                pix_valid,
    input  logic                pix_last,
    input  logic                flush,
    input  logic [PIX_IN_W-1:0] pix_data,
    output logic                word_ready,
    output logic [WORD_W-1:0]   word_data
);

    localparam int PPW    = ppw(WORD_W, PIX_W);
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] pack_reg;
    logic [WORD_W-1:0] merged;
    logic [PIX_W-1:0]  pix_trunc;
    logic [PIX_W-1:0]  pix_store;
    logic              unused_lsbs;

    // Low input bits are dropped by truncation; fold them so they are visibly consumed
    assign unused_lsbs = ^pix_data;
    assign pix_trunc   = pix_data[PIX_IN_W-1 -: PIX_W];

`ifdef IPSM_INVERT_EN
    assign pix_store = ~pix_trunc;
`else
    assign pix_store = pix_trunc;
`endif

    // Current word with the incoming pixel dropped into its lane
    always_comb begin
        merged = pack_reg;
        merged[lane*PIX_W +: PIX_W] = pix_store;
    end

    // Lane/packing state and the single-cycle word-ready strobe with its data
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_reg   <= '0;
            lane       <= '0;
            word_ready <= 1'b0;
            word_data  <= '0;
        end else begin
            word_ready <= 1'b0;
            if (clear) begin
                pack_reg <= '0;
                lane     <= '0;
            end else if (pix_valid) begin
                if (lane == LANE_W'(PPW - 1) || pix_last) begin
                    word_ready <= 1'b1;
                    word_data  <= merged;
                    pack_reg   <= '0;
                    lane       <= '0;
                end else begin
                    pack_reg <= merged;
                    lane     <= lane + 1'b1;
                end
            end else if (flush && lane != '0) begin
                // Unfilled lanes are already zero, which gives the pad for free
                word_ready <= 1'b1;
                word_data  <= pack_reg;
                pack_reg   <= '0;
                lane       <= '0;
            end
        end
    end

endmodule

// File: rtl/ipsm_frame_packer.sv
// rtl/ipsm_frame_packer.sv - frame-aligned capture FSM packing one frame into DMEM; IPSM_INVERT_EN selects inverted storage
module ipsm_frame_packer
    import ipsm_pkg::*;
#(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int PIX_IN_W  = 12,
    parameter int PIX_W     = 8,
    parameter int WORD_W    = 256,
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 0
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iEnable,
    input  logic                iStart,
    input  logic                iFVAL,
    input  logic                iDVAL,
    input  logic [PIX_IN_W-1:0] iDATA,
    output logic                oBusy,
    output logic                oDone,
    output logic                oErr,
    output logic [15:0]         oPixCount,
    output logic                oDmem_wren,
    output logic [ADDR_W-1:0]   oDmem_addr,
    output logic [WORD_W-1:0]   oDmem_data
);

    localparam int PPW    = ppw(WORD_W, PIX_W);
    localparam int NPIX   = npix(IMG_W, IMG_H);
    localparam int NWORDS = nwords(NPIX, PPW);

    if (BASE_ADDR + NWORDS > (1 << ADDR_W)) begin : g_addr_check
        $error("frame does not fit in DMEM address range");
    end
    if (PIX_W > PIX_IN_W || (WORD_W % PIX_W) != 0) begin : g_width_check
        $error("pixel width does not divide the word or exceeds the input width");
    end

    state_t            state, state_next;
    logic              fval_q;
    logic              fval_rise;
    logic [15:0]       count;
    logic [ADDR_W-1:0] addr;
    logic              err_q;
    logic              accept;
    logic              flush;
    logic              word_ready;

    assign fval_rise = iFVAL && !fval_q;

    // State register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus per-cycle pixel accept and flush requests
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (iStart && iEnable) state_next = ARM;
            end
            ARM: begin
                if (!iEnable)       state_next = IDLE;
                else if (fval_rise) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (!iEnable) begin
                    state_next = IDLE;
                end else if (count == 16'(NPIX)) begin
                    // The final word is on the bus this cycle
                    if (word_ready) state_next = DONE;
                end else if (!iFVAL) begin
                    flush      = 1'b1;
                    state_next = FLUSH;
                end else if (iDVAL) begin
                    accept = 1'b1;
                end
            end
            FLUSH: begin
                state_next = iEnable ? DONE : IDLE;
            end
            DONE: begin
                if (!iEnable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame-edge history, pixel count, write address and short-frame flag
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fval_q <= 1'b0;
            count  <= '0;
            addr   <= '0;
            err_q  <= 1'b0;
        end else begin
            fval_q <= iFVAL;

            if (state == ARM && state_next == CAPTURE) begin
                count <= '0;
            end else if (accept) begin
                count <= count + 16'd1;
            end

            if (state == IDLE && state_next == ARM) begin
                addr <= ADDR_W'(BASE_ADDR);
            end else if (word_ready) begin
                addr <= addr + 1'b1;
            end

            if (state_next == DONE) begin
                err_q <= (state == FLUSH) || (state == DONE && err_q);
            end else begin
                err_q <= 1'b0;
            end
        end
    end

    ipsm_word_packer #(
        .PIX_IN_W (PIX_IN_W),
        .PIX_W    (PIX_W),
        .WORD_W   (WORD_W)
    ) u_packer (
        .clk        (iCLK),
        .rst        (iRST),
        .clear      (state == IDLE || state == ARM),
        .pix_valid  (accept),
        .pix_last   (count == 16'(NPIX - 1)),
        .flush      (flush),
        .pix_data   (iDATA),
        .word_ready (word_ready),
        .word_data  (oDmem_data)
    );

    assign oBusy      = (state == ARM) || (state == CAPTURE) || (state == FLUSH);
    assign oDone      = (state == DONE);
    assign oErr       = err_q;
    assign oPixCount  = count;
    assign oDmem_wren = word_ready;
    assign oDmem_addr = addr;

endmodule

// File: tb/tb_ipsm_frame_packer.sv
// tb/tb_ipsm_frame_packer.sv - directed self-checking bench for ipsm_frame_packer
module tb_ipsm_frame_packer;

    logic         clk = 1'b0;
    logic         rst, en, start, fval, dval;
    logic [11:0]  data;

    logic         busy, done, err, wren;
    logic [15:0]  pcnt;
    logic [6:0]   addr;
    logic [255:0] wdata;

    logic         busy_b, done_b, err_b, wren_b;
    logic [15:0]  pcnt_b;
    logic [6:0]   addr_b;
    logic [255:0] wdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    int           wa[$];
    logic [255:0] wd[$];
    int           wb[$];

    typedef struct {
        logic [11:0] pix;
        logic [7:0]  trunc;
    } vec_t;
    vec_t vt[8];

    always #5 clk = ~clk;

    ipsm_frame_packer dut (
        .iCLK(clk), .iRST(rst), .iEnable(en), .iStart(start),
        .iFVAL(fval), .iDVAL(dval), .iDATA(data),
        .oBusy(busy), .oDone(done), .oErr(err), .oPixCount(pcnt),
        .oDmem_wren(wren), .oDmem_addr(addr), .oDmem_data(wdata)
    );

    ipsm_frame_packer #(.BASE_ADDR(64)) dut_b (
        .iCLK(clk), .iRST(rst), .iEnable(en), .iStart(start),
        .iFVAL(fval), .iDVAL(dval), .iDATA(data),
        .oBusy(busy_b), .oDone(done_b), .oErr(err_b), .oPixCount(pcnt_b),
        .oDmem_wren(wren_b), .oDmem_addr(addr_b), .oDmem_data(wdata_b)
    );

    // Write logger for both instances
    always @(negedge clk) begin
        if (wren) begin
            wa.push_back(int'(addr));
            wd.push_back(wdata);
        end
        if (wren_b) wb.push_back(int'(addr_b));
    end

    function automatic logic [7:0] expb(input logic [7:0] t);
`ifdef IPSM_INVERT_EN
        return ~t;
`else
        return t;
`endif
    endfunction

    // Expected word w of a frame whose pixel i carries value i[7:0] in its top bits
    function automatic logic [255:0] model_word(input int w, input int n);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 32; k++)
            if (w * 32 + k < n) r[k*8 +: 8] = expb(8'(w * 32 + k));
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wb.delete();
    endtask

    task automatic arm();
        en = 1'b1; start = 1'b1; tick();
        start = 1'b0; tick();
    endtask

    task automatic fstart();
        fval = 1'b1; tick(); tick();
    endtask

    task automatic fend();
        dval = 1'b0; tick();
        fval = 1'b0; tick();
    endtask

    task automatic pixels(input int from, input int n, input bit tab);
        for (int i = from; i < from + n; i++) begin
            dval = 1'b1;
            data = tab ? vt[i % 8].pix : {8'(i), 4'h0};
            tick();
        end
        dval = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 2000) begin
            tick();
            k++;
        end
        check(name, done, 1'b1);
        tick();
    endtask

    task automatic check_words(input string name, input int n);
        int nw;
        nw = (n + 31) / 32;
        check({name, "_nwr"}, wa.size(), nw);
        check({name, "_nwr_b"}, wb.size(), nw);
        for (int w = 0; w < nw && w < wa.size(); w++) begin
            check($sformatf("%s_addr%0d", name, w), wa[w], w);
            check($sformatf("%s_data%0d", name, w), wd[w], model_word(w, n));
        end
        for (int w = 0; w < nw && w < wb.size(); w++)
            check($sformatf("%s_addr_b%0d", name, w), wb[w], 64 + w);
    endtask

    initial begin
        vt[0] = '{12'h000, 8'h00};
        vt[1] = '{12'hFFF, 8'hFF};
        vt[2] = '{12'hFF0, 8'hFF};
        vt[3] = '{12'h00F, 8'h00};
        vt[4] = '{12'h123, 8'h12};
        vt[5] = '{12'hA5C, 8'hA5};
        vt[6] = '{12'h800, 8'h80};
        vt[7] = '{12'h7FF, 8'h7F};

        rst = 1'b1; en = 1'b0; start = 1'b0; fval = 1'b0; dval = 1'b0; data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_pcnt", pcnt, 16'd0);
        check("rst_wren", wren, 1'b0);
        check("rst_addr", addr, 7'd0);
        check("rst_data", wdata, 256'd0);

        // Truncation table: an 8-pixel short frame lands in one padded word
        clear_log();
        arm();
        check("arm_busy", busy, 1'b1);
        fstart();
        pixels(0, 8, 1'b1);
        fend();
        wait_done("tab_done");
        check("tab_err", err, 1'b1);
        check("tab_pcnt", pcnt, 16'd8);
        check("tab_nwr", wa.size(), 1);
        if (wa.size() > 0) begin
            for (int k = 0; k < 8; k++)
                check($sformatf("tab_lane%0d", k), wd[0][k*8 +: 8], expb(vt[k].trunc));
            check("tab_pad", wd[0][255:64], 192'd0);
        end
        en = 1'b0; tick();

        // Full frame with a start pulse mid-capture; then done handshake
        clear_log();
        arm();
        fstart();
        pixels(0, 400, 1'b0);
        start = 1'b1;
        pixels(400, 1, 1'b0);
        start = 1'b0;
        pixels(401, 383, 1'b0);
        fend();
        wait_done("full_done");
        check("full_err", err, 1'b0);
        check("full_pcnt", pcnt, 16'd784);
        check("full_busy", busy, 1'b0);
        check_words("full", 784);
        if (wd.size() == 25) begin
            check("full_w0_lo", wd[0][7:0], expb(8'h00));
            check("full_w0_hi", wd[0][255:248], expb(8'h1F));
            check("full_w24_hi", wd[24][255:128], 128'd0);
        end
        repeat (5) tick();
        start = 1'b1; tick();
        start = 1'b0; tick();
        check("hold_done", done, 1'b1);
        check("hold_busy", busy, 1'b0);
        en = 1'b0; tick();
        check("ack_done", done, 1'b0);
        check("ack_err", err, 1'b0);

        // Armed inside a frame: that frame is skipped, the next one captured
        clear_log();
        fval = 1'b1; tick();
        arm();
        pixels(0, 50, 1'b0);
        check("skip_nwr", wa.size(), 0);
        check("skip_busy", busy, 1'b1);
        fend();
        fstart();
        pixels(0, 784, 1'b0);
        fend();
        wait_done("skip_done");
        check("skip_pcnt", pcnt, 16'd784);
        check_words("skip", 784);
        en = 1'b0; tick();

        // Short frame of 100 pixels
        clear_log();
        arm();
        fstart();
        pixels(0, 100, 1'b0);
        fend();
        wait_done("short_done");
        check("short_err", err, 1'b1);
        check("short_pcnt", pcnt, 16'd100);
        check_words("short", 100);
        en = 1'b0; tick();

        // Abort after 40 pixels, then re-arm from the base address
        clear_log();
        arm();
        fstart();
        pixels(0, 40, 1'b0);
        en = 1'b0; tick();
        check("abort_busy", busy, 1'b0);
        pixels(40, 20, 1'b0);
        fend();
        repeat (3) tick();
        check("abort_nwr", wa.size(), 1);
        if (wa.size() > 0) check("abort_addr", wa[0], 0);
        check("abort_done", done, 1'b0);
        clear_log();
        arm();
        fstart();
        pixels(0, 33, 1'b0);
        fend();
        wait_done("rearm_done");
        check("rearm_pcnt", pcnt, 16'd33);
        check_words("rearm", 33);
        en = 1'b0; tick();

        // Reset pulse mid-capture
        clear_log();
        arm();
        fstart();
        pixels(0, 40, 1'b0);
        rst = 1'b1; tick();
        rst = 1'b0;
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_err", err, 1'b0);
        check("mrst_pcnt", pcnt, 16'd0);
        check("mrst_wren", wren, 1'b0);
        check("mrst_addr", addr, 7'd0);
        check("mrst_data", wdata, 256'd0);
        clear_log();
        pixels(40, 30, 1'b0);
        fend();
        repeat (3) tick();
        check("mrst_nwr", wa.size(), 0);
        check("mrst_busy2", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ipsm_frame_packer.md
Name: ipsm_frame_packer

Overview:
- Parametrised successor to the camera-side capture FSM.
- Takes the downsampled grayscale pixel stream (after crop/downsample) and packs one complete frame into wide DMEM words. Default frame is 28x28, 8-bit pixels, 256-bit words.
- Frame-aligned: arms on a CPU/user request and captures exactly one whole frame starting at the next frame start. Pads the last word and reports completion or short-frame error to the CPU.
- Single clock domain; the pipeline stream is already synchronous to iCLK.

Parameters:
- IMG_W, 28, frame width in pixels.
- IMG_H, 28, frame height in pixels.
- PIX_IN_W, 12, input pixel width.
- PIX_W, 8, stored pixel width; MSBs of input kept, must be <= PIX_IN_W.
- WORD_W, 256, DMEM word width; must be a multiple of PIX_W.
- ADDR_W, 7, DMEM address width.
- BASE_ADDR, 0, first DMEM word address.

Ports:
- iCLK, in, 1, clock.
- iRST, in, 1, synchronous active-high reset.
- iEnable, in, 1, CPU enable; level; deassert aborts or acknowledges.
- iStart, in, 1, capture request pulse (user key or CPU).
- iFVAL, in, 1, frame valid from the pipeline.
- iDVAL, in, 1, pixel valid.
- iDATA, in, PIX_IN_W, pixel value.
- oBusy, out, 1, armed or capturing.
- oDone, out, 1, frame stored; held until iEnable low.
- oErr, out, 1, short frame (valid together with oDone).
- oPixCount, out, 16, pixels accepted in the current or last frame.
- oDmem_wren, out, 1, DMEM write strobe.
- oDmem_addr, out, ADDR_W, DMEM write address.
- oDmem_data, out, WORD_W, DMEM write data.

Behaviour:
- Derived constants:
  - PPW = WORD_W/PIX_W (default 32).
  - NPIX = IMG_W*IMG_H (default 784).
  - NWORDS = ceil(NPIX/PPW) (default 25).
  - BASE_ADDR+NWORDS must fit in ADDR_W; checked at elaboration.
- Reset: state IDLE; all outputs 0; packing register, lane index and pixel count all 0.
- IDLE -> ARM when iStart && iEnable. iStart in any other state is ignored.
- ARM: waits for a rising edge of iFVAL (registered previous value 0, current 1), then -> CAPTURE with the count cleared. If iFVAL is already high when armed, the current frame is skipped and capture starts at the next frame.
- CAPTURE, on each iDVAL while count < NPIX:
  - Lane k = count mod PPW receives iDATA[PIX_IN_W-1 -: PIX_W] at bits [k*PIX_W +: PIX_W]; the first pixel goes in the LSBs.
  - Count increments.
- Word write: when lane PPW-1 fills, or pixel NPIX is accepted, the next cycle outputs a single-cycle oDmem_wren with the word. Address starts at BASE_ADDR and increments after each write. The packing register clears for the next word.
- After pixel NPIX: remaining iDVAL in the frame is ignored. -> DONE once the final write issues; oErr=0.
- iFVAL falls with count < NPIX (short frame):
  - FLUSH writes the partial word with unused lanes zero, but only if count mod PPW != 0.
  - Then -> DONE with oErr=1.
  - Words beyond the last written are not touched.
- DONE: oDone=1 and oBusy=0. -> IDLE when iEnable falls; oDone and oErr clear the same cycle.
- iEnable low in ARM, CAPTURE or FLUSH: abort to IDLE next cycle. No further writes; oDone stays 0. A write already issued that cycle completes.
- oBusy = 1 in ARM, CAPTURE and FLUSH.
- Write latency: 1 cycle from the completing iDVAL to oDmem_wren. One pixel per cycle is sustained with no stalls; back-to-back word completions are impossible for PPW > 1.
- Reset mid-operation returns to the reset state at the next edge; a partial word is discarded.

Optional Feature:
- Macro: IPSM_INVERT_EN.
- Defined: each stored pixel is the bitwise inverse of its truncated value (light background becomes 0, matching the NN training polarity). Pad lanes stay 0.
- Undefined: pixels are stored uninverted.
- Counts, addresses and timing are identical in both builds.

Decomposition:
- Package ipsm_pkg:
  - state enum {IDLE, ARM, CAPTURE, FLUSH, DONE};
  - helper functions for PPW, NPIX and NWORDS.
- Sub-module ipsm_word_packer:
  - lane index, packing register, truncation/inversion, flush-with-zero-pad and word-ready strobe.
  - The top level keeps the FSM, frame-edge detect, count and address.

Test Plan:
- Full frame: iFVAL high, 784 iDVAL with iDATA={i[7:0],4'h0}, i=0..783 ->
  - 25 writes at addresses 0..24;
  - word0 bits[7:0]=8'h00, bits[255:248]=8'h1F;
  - word24 bits[127:0] hold pixels 768..783 and bits[255:128]=0;
  - oDone=1, oErr=0, oPixCount=784.
- Armed while iFVAL already high: first frame ignored (no writes); the next frame is captured fully.
- Short frame: iFVAL drops after 100 pixels -> 4 writes, addresses 0..3; word3 lanes 0..3 valid and the rest 0; oErr=1, oPixCount=100.
- Abort: iEnable dropped after 40 pixels -> exactly 1 write; IDLE next cycle; oDone=0; a subsequent iStart re-arms with the address back at BASE_ADDR.
- Done handshake and ignored start: iStart during CAPTURE has no effect; oDone holds until iEnable falls, then clears the same cycle. With BASE_ADDR=64 the writes go to 64..88.
- iRST pulse mid-CAPTURE: outputs 0 next cycle, no further writes; with IPSM_INVERT_EN defined, a pixel input of 12'hFF0 stores 8'h00.
